// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dm
// Description : Shared debug-module types. Holds the DMI request/response
//               structures and DTM operation encoding used between the DTM,
//               the DMI request buffer and the debug module.
// Revision    : 1.0  initial release
// ============================================================================
package dm;

    // DTM operation encoding carried in a DMI request.
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    // DMI request: register address, operation and write data.
    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    // DMI response: read data and status code.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // Status code returned when an operation could not complete.
    localparam logic [1:0] DmiRespFailed = 2'h2;

endpackage : dm
`default_nettype wire

// File: rtl/dmi_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dmi_req_fifo
// Description : Parameterized synchronous FIFO with asynchronous active-high
//               reset. The head entry is presented combinationally.
//   clk_i   in  : clock
//   rst_i   in  : asynchronous reset, active-high
//   push_i  in  : write data_i (ignored when full)
//   data_i  in  : entry to write
//   pop_i   in  : drop head entry (ignored when empty)
//   full_o  out : no free entry
//   empty_o out : no valid entry
//   head_o  out : oldest entry
// Revision    : 1.0  initial release
// ============================================================================
module dmi_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic [c_ptr_w-1:0] w_rd_ptr;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (r_count == c_depth);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[w_rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow; a single
    // entry FIFO has nothing to index, so its pointers are constant.
    generate
        if (DEPTH > 1) begin : g_ptr_wrap
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                    if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
            end

            assign w_wr_ptr = r_wr_ptr;
            assign w_rd_ptr = r_rd_ptr;
        end else begin : g_ptr_single
            assign w_wr_ptr = '0;
            assign w_rd_ptr = '0;
        end
    endgenerate

    // Storage is cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : dmi_req_fifo
`default_nettype wire

// File: rtl/dmi_req_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmi_req_buffer
// Description : DMI front-end between the DTM and the debug module. Queues up
//               to Depth requests, forwards them one at a time and returns
//               responses in request order. Optional timeout logic
//               (macro DMI_REQ_BUFFER_TIMEOUT_EN) synthesizes a failed
//               response when the DM never answers and drains the late
//               response afterwards.
//   clk_i / rst_i                 : clock, asynchronous active-high reset
//   dtm_req_valid_i/ready_o/req_i : request channel from the DTM
//   dtm_resp_valid_o/ready_i/resp_o: response channel to the DTM
//   dm_req_valid_o/ready_i/req_o  : request channel to the DM
//   dm_resp_valid_i/ready_o/resp_i: response channel from the DM
//   timeouts_o                    : saturating count of synthesized failures
// Revision    : 1.0  initial release
// ============================================================================
module dmi_req_buffer
    import dm::*;
#(
    parameter int Depth         = 2,
    parameter int TimeoutCycles = 1023
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          dtm_req_valid_i,
    output logic          dtm_req_ready_o,
    input  dm::dmi_req_t  dtm_req_i,
    output logic          dtm_resp_valid_o,
    input  logic          dtm_resp_ready_i,
    output dm::dmi_resp_t dtm_resp_o,
    output logic          dm_req_valid_o,
    input  logic          dm_req_ready_i,
    output dm::dmi_req_t  dm_req_o,
    input  logic          dm_resp_valid_i,
    output logic          dm_resp_ready_o,
    input  dm::dmi_resp_t dm_resp_i,
    output logic [7:0]    timeouts_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    generate
        if (Depth < 1 || (Depth & (Depth - 1)) != 0 || TimeoutCycles < 1) begin : g_cfg_check
            $error("dmi_req_buffer: Depth must be a power of two >= 1 and TimeoutCycles >= 1");
        end
    endgenerate

    state_e    r_state;
    state_e    w_state_next;
    dmi_resp_t r_resp;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_resp_take;
    logic      w_timeout;
    logic      w_stale;

    assign w_push      = dtm_req_valid_i & ~w_fifo_full;
    assign w_pop       = (r_state == ST_ISSUE) & dm_req_ready_i;
    assign w_resp_take = (r_state == ST_WAIT) & dm_resp_valid_i;

    assign dtm_req_ready_o  = ~w_fifo_full;
    assign dm_req_valid_o   = (r_state == ST_ISSUE);
    assign dtm_resp_valid_o = (r_state == ST_RESP);
    assign dtm_resp_o       = r_resp;

    dmi_req_fifo #(
        .DEPTH (Depth),
        .WIDTH ($bits(dmi_req_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (dtm_req_i),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (dm_req_o)
    );

`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
    localparam int c_timer_w = $clog2(TimeoutCycles + 1);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TimeoutCycles - 1);

    logic [c_timer_w-1:0] r_timer;
    logic                 r_stale;
    logic [7:0]           r_timeouts;

    // A real response on the expiry cycle takes priority over the timeout.
    assign w_timeout       = (r_state == ST_WAIT) & ~dm_resp_valid_i & (r_timer == c_timer_last);
    assign w_stale         = r_stale;
    assign dm_resp_ready_o = (r_state == ST_WAIT) | r_stale;
    assign timeouts_o      = r_timeouts;

    // One timer serves both the WAIT timeout and the stale-drain window;
    // the two never overlap because nothing issues while stale is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer    <= '0;
            r_stale    <= 1'b0;
            r_timeouts <= '0;
        end else if (w_pop) begin
            r_timer <= '0;
        end else if (r_state == ST_WAIT) begin
            if (w_timeout) begin
                r_timer <= '0;
                r_stale <= 1'b1;
                if (r_timeouts != 8'hFF) begin
                    r_timeouts <= r_timeouts + 8'd1;
                end
            end else begin
                r_timer <= r_timer + c_timer_w'(1);
            end
        end else if (r_stale) begin
            // The late DM response is accepted here and silently dropped.
            if (dm_resp_valid_i || (r_timer == c_timer_last)) begin
                r_stale <= 1'b0;
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_timer_w'(1);
            end
        end
    end
`else
    assign w_timeout       = 1'b0;
    assign w_stale         = 1'b0;
    assign dm_resp_ready_o = (r_state == ST_WAIT);
    assign timeouts_o      = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_fifo_empty && !w_stale)  w_state_next = ST_ISSUE;
            ST_ISSUE: if (dm_req_ready_i)             w_state_next = ST_WAIT;
            ST_WAIT:  if (w_resp_take || w_timeout)   w_state_next = ST_RESP;
            ST_RESP:  if (dtm_resp_ready_i)           w_state_next = ST_IDLE;
            default:                                  w_state_next = ST_IDLE;
        endcase
    end

    // Response register holds steady through RESP until the DTM accepts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp <= '0;
        end else if (w_resp_take) begin
            r_resp <= dm_resp_i;
        end else if (w_timeout) begin
            r_resp <= '{data: 32'h0, resp: DmiRespFailed};
        end
    end

endmodule : dmi_req_buffer
`default_nettype wire

// File: tb/tb_dmi_req_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_req_buffer
// Description : Directed self-checking bench for dmi_req_buffer with a
//               behavioural DM responder and a response scoreboard queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmi_req_buffer;
    import dm::*;

    localparam int DEPTH = 2;
    localparam int TMO   = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       dtm_req_valid = 1'b0;
    logic       dtm_req_ready;
    dmi_req_t   dtm_req = '0;
    logic       dtm_resp_valid;
    logic       dtm_resp_ready = 1'b0;
    dmi_resp_t  dtm_resp;
    logic       dm_req_valid;
    logic       dm_req_ready = 1'b0;
    dmi_req_t   dm_req;
    logic       dm_resp_valid = 1'b0;
    logic       dm_resp_ready;
    dmi_resp_t  dm_resp = '0;
    logic [7:0] timeouts;

    dmi_req_buffer #(
        .Depth         (DEPTH),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dtm_req_valid_i  (dtm_req_valid),
        .dtm_req_ready_o  (dtm_req_ready),
        .dtm_req_i        (dtm_req),
        .dtm_resp_valid_o (dtm_resp_valid),
        .dtm_resp_ready_i (dtm_resp_ready),
        .dtm_resp_o       (dtm_resp),
        .dm_req_valid_o   (dm_req_valid),
        .dm_req_ready_i   (dm_req_ready),
        .dm_req_o         (dm_req),
        .dm_resp_valid_i  (dm_resp_valid),
        .dm_resp_ready_o  (dm_resp_ready),
        .dm_resp_i        (dm_resp),
        .timeouts_o       (timeouts)
    );

    always #5 clk_i = ~clk_i;

    int        checks   = 0;
    int        failures = 0;
    dmi_resp_t exp_q[$];

    // ---------------- DM behavioural model ----------------
    bit       m_ready_en = 1'b1;
    bit       m_silent   = 1'b0;
    int       m_delay    = 0;
    logic     m_pending;
    int       m_cnt;
    dmi_req_t m_req;

    function automatic dmi_resp_t dm_model(input dmi_req_t r);
        dmi_resp_t x;
        x.resp = 2'h0;
        if (r.op == DTM_WRITE)    x.data = r.data;
        else if (r.addr == 7'h11) x.data = 32'hDEADBEEF;
        else                      x.data = {25'h0, r.addr} ^ 32'hC0DE0000;
        return x;
    endfunction

    function automatic dmi_req_t mk_req(input logic [6:0] a, input dtm_op_e o, input logic [31:0] d);
        dmi_req_t r;
        r.addr = a;
        r.op   = o;
        r.data = d;
        return r;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pending <= 1'b0;
            m_cnt     <= 0;
            m_req     <= '0;
        end else begin
            if (dm_resp_valid && dm_resp_ready) m_pending <= 1'b0;
            else if (m_pending && m_cnt > 0)    m_cnt <= m_cnt - 1;
            if (dm_req_valid && dm_req_ready) begin
                m_pending <= 1'b1;
                m_cnt     <= m_delay;
                m_req     <= dm_req;
            end
        end
    end

    always @(negedge clk_i) begin
        dm_req_ready  = m_ready_en && !m_pending;
        dm_resp_valid = m_pending && (m_cnt == 0) && !m_silent;
        dm_resp       = dm_resp_valid ? dm_model(m_req) : '0;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input dmi_req_t r, input dmi_resp_t exp, input string tag);
        bit ok;
        ok = 1'b0;
        dtm_req_valid = 1'b1;
        dtm_req       = r;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (dtm_req_ready) ok = 1'b1;
            @(negedge clk_i);
        end
        dtm_req_valid = 1'b0;
        check({tag, "_accept"}, 64'(ok), 64'd1);
        if (ok) exp_q.push_back(exp);
    endtask

    task automatic get_resp(input string tag);
        bit        ok;
        dmi_resp_t e;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (dtm_resp_valid) ok = 1'b1;
            else @(negedge clk_i);
        end
        check({tag, "_valid"}, 64'(ok), 64'd1);
        if (ok) begin
            check({tag, "_queued"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(tag, 64'(dtm_resp), 64'(e));
            end
            dtm_resp_ready = 1'b1;
            @(negedge clk_i);
            dtm_resp_ready = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(dtm_req_ready),  64'd1);
        check({tag, "_dm_valid"},   64'(dm_req_valid),   64'd0);
        check({tag, "_dtm_valid"},  64'(dtm_resp_valid), 64'd0);
        check({tag, "_dm_rready"},  64'(dm_resp_ready),  64'd0);
        check({tag, "_dm_req"},     64'(dm_req),         64'd0);
        check({tag, "_dtm_resp"},   64'(dtm_resp),       64'd0);
        check({tag, "_timeouts"},   64'(timeouts),       64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        dmi_req_t  r1, r2, r3;
        dmi_resp_t failed;
        bit        found;
        int        n;
        failed = '{data: 32'h0, resp: DmiRespFailed};

        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("rst");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single read with latency checks.
        m_ready_en = 1'b1;
        m_delay    = 0;
        r1 = mk_req(7'h11, DTM_READ, 32'h0);
        push_req(r1, dm_model(r1), "t1");
        check("t1_idle_cycle", 64'(dm_req_valid), 64'd0);
        @(negedge clk_i);
        check("t1_issue", 64'(dm_req_valid), 64'd1);
        check("t1_head", 64'(dm_req), 64'(r1));
        @(negedge clk_i);
        check("t1_wait_ready", 64'(dm_resp_ready), 64'd1);
        check("t1_not_yet", 64'(dtm_resp_valid), 64'd0);
        @(negedge clk_i);
        check("t1_resp_lat", 64'(dtm_resp_valid), 64'd1);
        get_resp("t1_data");

        // FIFO full with DM stalled, responses in push order.
        m_ready_en = 1'b0;
        @(negedge clk_i);
        r1 = mk_req(7'h04, DTM_WRITE, 32'd1);
        r2 = mk_req(7'h04, DTM_WRITE, 32'd2);
        r3 = mk_req(7'h04, DTM_WRITE, 32'd3);
        push_req(r1, dm_model(r1), "t2_p1");
        push_req(r2, dm_model(r2), "t2_p2");
        dtm_req_valid = 1'b1;
        dtm_req       = r3;
        for (int i = 0; i < 3; i++) begin
            check("t2_full", 64'(dtm_req_ready), 64'd0);
            @(negedge clk_i);
        end
        check("t2_stalled_issue", 64'(dm_req_valid), 64'd1);
        m_ready_en = 1'b1;
        push_req(r3, dm_model(r3), "t2_p3");
        get_resp("t2_r1");
        get_resp("t2_r2");
        get_resp("t2_r3");

        // DTM back-pressure: response held, no new issue.
        r1 = mk_req(7'h05, DTM_WRITE, 32'hA5A5_0001);
        r2 = mk_req(7'h06, DTM_READ,  32'h0);
        push_req(r1, dm_model(r1), "t3_p1");
        push_req(r2, dm_model(r2), "t3_p2");
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (dtm_resp_valid) found = 1'b1;
            else @(negedge clk_i);
        end
        check("t3_valid", 64'(found), 64'd1);
        if (found) begin
            for (int i = 0; i < 5; i++) begin
                check("t3_hold", 64'(dtm_resp), 64'(exp_q[0]));
                check("t3_no_issue", 64'(dm_req_valid), 64'd0);
                @(negedge clk_i);
            end
        end
        get_resp("t3_a");
        get_resp("t3_b");

`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
        // DM silent: synthesized failure, stale drain, then next issue.
        m_silent = 1'b1;
        r1 = mk_req(7'h07, DTM_WRITE, 32'h1111_1111);
        r2 = mk_req(7'h03, DTM_READ,  32'h0);
        push_req(r1, failed, "t4_p1");
        push_req(r2, dm_model(r2), "t4_p2");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dm_req_valid) found = 1'b1;
            else @(negedge clk_i);
        end
        check("t4_issue", 64'(found), 64'd1);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            n++;
            if (dtm_resp_valid) break;
        end
        check("t4_timeout_lat", 64'(n), 64'(TMO + 1));
        check("t4_count", 64'(timeouts), 64'd1);
        check("t4_stale_ready", 64'(dm_resp_ready), 64'd1);
        m_silent = 1'b0;
        get_resp("t4_failed");
        check("t4_stale_block", 64'(dm_req_valid), 64'd0);
        get_resp("t4_after");
        check("t4_count_hold", 64'(timeouts), 64'd1);

        // Response exactly on the expiry cycle wins.
        m_delay = TMO - 1;
        r1 = mk_req(7'h22, DTM_READ, 32'h0);
        push_req(r1, dm_model(r1), "t5_p");
        get_resp("t5_data");
        check("t5_count", 64'(timeouts), 64'd1);
        check("t5_not_stale", 64'(dm_resp_ready), 64'd0);
        m_delay = 0;
`else
        // Without timeouts a silent DM is waited on indefinitely.
        m_silent = 1'b1;
        r1 = mk_req(7'h07, DTM_WRITE, 32'h1111_1111);
        push_req(r1, dm_model(r1), "t4_p");
        repeat (3 * TMO + 5) @(negedge clk_i);
        check("t4_no_resp", 64'(dtm_resp_valid), 64'd0);
        check("t4_count", 64'(timeouts), 64'd0);
        check("t4_still_wait", 64'(dm_resp_ready), 64'd1);
        m_silent = 1'b0;
        get_resp("t4_late");
`endif

        // Reset during WAIT.
        m_silent = 1'b1;
        r1 = mk_req(7'h09, DTM_WRITE, 32'h0BAD_0BAD);
        push_req(r1, dm_model(r1), "t6_p");
        repeat (3) @(negedge clk_i);
        check("t6_in_wait", 64'(dm_resp_ready), 64'd1);
        rst_i    = 1'b1;
        m_silent = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("t6_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            check("t6_empty", 64'(dm_req_valid), 64'd0);
            check("t6_no_resp", 64'(dtm_resp_valid), 64'd0);
            @(negedge clk_i);
        end
        r1 = mk_req(7'h12, DTM_WRITE, 32'h1234_5678);
        push_req(r1, dm_model(r1), "t6_post_p");
        get_resp("t6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmi_req_buffer
`default_nettype wire
